// File: rtl/ddr5_pkg.sv
// ddr5_pkg: shared data width, default burst length and burst FSM state type.
package ddr5_pkg;
    localparam int DDR5_DATA_W = 64;
    localparam int DDR5_BURST_LEN = 8;
    typedef enum logic {IDLE, BURST} burst_state_e;
endpackage

// File: rtl/ddr5_burst_assembler_if.sv
// ddr5_burst_assembler_if: word input, burst beat output and status bundle of the assembler.
interface ddr5_burst_assembler_if import ddr5_pkg::*; #(
    parameter int DEPTH = 32
);
    logic [DDR5_DATA_W-1:0] in_data;
    logic                   in_valid;
    logic [DDR5_DATA_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [15:0]            burst_cnt;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last, level, overflow, burst_cnt
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last, level, overflow, burst_cnt
    );
endinterface

// File: rtl/ddr5_sync_fifo.sv
// ddr5_sync_fifo: show-ahead FIFO with occupancy output; the caller decides whether a write is legal.
module ddr5_sync_fifo #(
    parameter int DEPTH = 32,
    parameter int W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
        rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
        level_d = level_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_en_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
endmodule

// File: rtl/ddr5_burst_assembler.sv
// ddr5_burst_assembler: buffers DDR words and emits them only as complete BURST_LEN-beat bursts.
module ddr5_burst_assembler import ddr5_pkg::*; #(
    parameter int BURST_LEN = DDR5_BURST_LEN,
    parameter int DEPTH = 32
) (
    input logic clk,
    input logic rst,
    ddr5_burst_assembler_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(BURST_LEN);

    burst_state_e  state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   burst_cnt_q, burst_cnt_d;
    logic          overflow_q, overflow_d;
    logic [LW-1:0] level, level_post;
    logic          xfer, wr_ok, last;

    assign bus.out_valid = state_q == BURST;
    assign last = bus.out_valid && beat_q == BW'(BURST_LEN - 1);
    assign xfer = bus.out_valid && bus.out_ready;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign wr_ok = bus.in_valid && (level < LW'(DEPTH) || xfer);
    assign level_post = level + LW'(wr_ok) - LW'(xfer);

    ddr5_sync_fifo #(.DEPTH(DEPTH), .W(DDR5_DATA_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en_i(wr_ok),
        .wr_data_i(bus.in_data),
        .rd_en_i(xfer),
        .rd_data_o(bus.out_data),
        .level_o(level)
    );

    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        burst_cnt_d = burst_cnt_q;
        overflow_d = overflow_q | (bus.in_valid & ~wr_ok);
        if (state_q == IDLE) begin
            state_d = level >= LW'(BURST_LEN) ? BURST : IDLE;
            beat_d = '0;
        end else if (xfer) begin
            beat_d = beat_q + 1'b1;
            if (last) begin
                burst_cnt_d = burst_cnt_q + 16'd1;
                state_d = level_post >= LW'(BURST_LEN) ? BURST : IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q <= '0;
            burst_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            burst_cnt_q <= burst_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_last = last;
    assign bus.level = level;
    assign bus.overflow = overflow_q;
    assign bus.burst_cnt = burst_cnt_q;
endmodule

// File: tb/tb_ddr5_burst_assembler.sv
// tb_ddr5_burst_assembler: directed and random stimulus scored against a queue-based burst model.
module tb_ddr5_burst_assembler;
    localparam int BL = 8;
    localparam int DEPTH = 32;

    typedef struct {
        logic [63:0] d;
        bit          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ddr5_burst_assembler_if #(.DEPTH(DEPTH)) bus ();

    ddr5_burst_assembler #(.BURST_LEN(BL), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    beat_t exp_q[$];
    bit armed = 0;
    bit m_valid = 0;
    bit m_ovf = 0;
    int m_level = 0;
    int m_beat = 0;
    int m_acc = 0;
    logic [15:0] m_bursts = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compares outputs mid-cycle, then advances the model across the next rising edge.
    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
            check("out_last", {63'd0, bus.out_last}, {63'd0, m_valid && m_beat == BL - 1});
            check("level", 64'(bus.level), 64'(m_level));
            check("overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
            check("burst_cnt", 64'(bus.burst_cnt), 64'(m_bursts));
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat: got %0h, want no beat at %0t", bus.out_data, $time);
                end else begin
                    check("beat_data", bus.out_data, exp_q[0].d);
                    check("beat_last", {63'd0, bus.out_last}, {63'd0, exp_q[0].last});
                    if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
        if (rst) begin
            armed = 1;
            m_valid = 0;
            m_ovf = 0;
            m_level = 0;
            m_beat = 0;
            m_acc = 0;
            m_bursts = '0;
            exp_q.delete();
        end else begin
            int pre;
            bit xfer, acc;
            pre = m_level;
            xfer = m_valid && bus.out_ready;
            acc = bus.in_valid && (pre < DEPTH || xfer);
            if (bus.in_valid && !acc) m_ovf = 1;
            m_level = pre + int'(acc) - int'(xfer);
            if (acc) begin
                exp_q.push_back('{d: bus.in_data, last: (m_acc % BL) == BL - 1});
                m_acc++;
            end
            if (xfer) begin
                m_beat++;
                if (m_beat == BL) begin
                    m_beat = 0;
                    m_bursts = m_bursts + 16'd1;
                    m_valid = m_level >= BL;
                end
            end else if (!m_valid) begin
                m_valid = pre >= BL;
                m_beat = 0;
            end
        end
    end

    task automatic drive(input bit v, input logic [63:0] d, input bit r, input bit rs);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = r;
        rst = rs;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(0, 64'd0, r, 0);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data = '0;
        bus.out_ready = 0;
        repeat (3) drive(0, 64'd0, 0, 1);
        // Single burst 1..8 with a ready consumer.
        for (int i = 1; i <= 8; i++) drive(1, 64'(i), 1, 0);
        idle(12, 1);
        // Seven words stay buffered, the eighth starts the burst.
        for (int i = 1; i <= 7; i++) drive(1, 64'h10 + 64'(i), 1, 0);
        idle(15, 1);
        drive(1, 64'h18, 1, 0);
        idle(12, 1);
        // Two bursts through a consumer that stalls every other cycle.
        for (int i = 0; i < 16; i++) drive(1, 64'h100 + 64'(i), i % 2 == 0, 0);
        for (int i = 0; i < 40; i++) drive(0, 64'd0, i % 2 == 0, 0);
        // Overflow: 33 words into a stalled buffer, then drain.
        drive(0, 64'd0, 0, 1);
        for (int i = 1; i <= 33; i++) drive(1, 64'(i), 0, 0);
        idle(3, 0);
        idle(40, 1);
        // Full buffer with a simultaneous write and transfer.
        drive(0, 64'd0, 0, 1);
        for (int i = 1; i <= 32; i++) drive(1, 64'h200 + 64'(i), 0, 0);
        idle(2, 0);
        drive(1, 64'h2AA, 1, 0);
        idle(3, 0);
        idle(40, 1);
        // Reset in the middle of a burst, with in_valid active during reset.
        for (int i = 1; i <= 8; i++) drive(1, 64'h300 + 64'(i), 1, 0);
        begin
            int n = 0;
            while (!(m_valid && m_beat == 4) && n < 40) begin
                drive(0, 64'd0, 1, 0);
                n++;
            end
            if (n == 40) begin
                checks++;
                errors++;
                $display("FAIL mid_burst_wait: got timeout, want beat 4 within 40 cycles");
            end
        end
        drive(1, 64'h3FF, 1, 1);
        idle(12, 1);
        // Random traffic with varying consumer pressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int pin, pout;
            pin = (i / 500) % 2 == 0 ? 3 : 1;
            pout = (i / 300) % 3;
            drive($urandom_range(0, 3) < pin, {$urandom, $urandom}, $urandom_range(0, 2) >= pout,
                  $urandom_range(0, 599) == 0);
        end
        idle(60, 1);
        @(posedge clk);
        #7;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr5_burst_assembler.md
DDR5_BURST_ASSEMBLER -- requirements
Module: ddr5_burst_assembler

Interface
REQ-001 Parameter: BURST_LEN, default 8, number of beats per output burst (power of 2, >=2).
REQ-002 Parameter: DEPTH, default 32, buffer depth in 64-bit words (power of 2, integer multiple of BURST_LEN, >=2*BURST_LEN).
REQ-003 Port: clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  64  combined DDR word from the clock-sync stage (its data_out).
REQ-006 Port: in_valid  input  1  word qualifier from the clock-sync stage (its sync_data_ready); no backpressure path exists upstream.
REQ-007 Port: out_data  output  64  current burst beat.
REQ-008 Port: out_valid  output  1  beat valid.
REQ-009 Port: out_ready  input  1  consumer accepts beat; transfer = out_valid & out_ready.
REQ-010 Port: out_last  output  1  marks final beat of a burst.
REQ-011 Port: level  output  $clog2(DEPTH)+1  words currently buffered.
REQ-012 Port: overflow  output  1  sticky flag: a word was dropped.
REQ-013 Port: burst_cnt  output  16  count of completed bursts, wraps 0xFFFF->0x0000.

Function
REQ-014 Write: when in_valid=1, in_data SHALL be stored at the write pointer if level<DEPTH, or if level=DEPTH and a transfer occurs in the same cycle.
REQ-015 Write while full without a same-cycle transfer: word dropped, pointers unchanged, overflow set to 1 from the next cycle until reset.
REQ-016 level: +1 on accepted write, -1 on transfer, unchanged on both or neither; updates the cycle after the event.
REQ-017 Pointers wrap modulo DEPTH; out_data SHALL be the word at the read pointer (show-ahead, combinational from buffer head).
REQ-018 FSM states: IDLE, BURST.
REQ-019 IDLE: out_valid=0; if registered level>=BURST_LEN, go to BURST next cycle with beat counter=0.
REQ-020 BURST: out_valid=1; the beat counter advances on each transfer; out_last=1 when beat counter=BURST_LEN-1.
REQ-021 out_valid held high with out_data stable while out_ready=0 (no beat withdrawn mid-burst).
REQ-022 On a transfer with out_last=1: burst_cnt+1; stay in BURST (counter=0) if the post-update level>=BURST_LEN, else go to IDLE.
REQ-023 Latency: BURST_LEN-th word accepted at edge N -> out_valid=1 after edge N+1; back-to-back bursts have zero idle cycles.
REQ-024 Partial bursts (<BURST_LEN words) SHALL never be emitted; they remain buffered.
REQ-025 Beat order SHALL equal arrival order; no word duplicated or reordered.

Reset
REQ-026 rst=1 at an edge: pointers=0, level=0, state=IDLE, beat counter=0, out_valid=0, out_last=0, overflow=0, burst_cnt=0; out_data is don't-care while out_valid=0.
REQ-027 Buffer storage SHALL NOT be reset.
REQ-028 Reset during BURST aborts the burst with no out_last and discards all buffered words; in_valid during reset is ignored.

Structure
REQ-029 Shared package ddr5_pkg SHALL hold DDR5_DATA_W=64, default BURST_LEN, and the FSM state type.
REQ-030 Storage and pointers SHALL be a sub-module ddr5_sync_fifo (show-ahead, level output); the FSM, beat counter and burst_cnt live in the top.

Verification
REQ-031 8 consecutive in_valid words 0x1..0x8, out_ready=1 -> out_valid 1 cycle after the 8th write, 8 beats 0x1..0x8, out_last on 0x8, burst_cnt=1, back to IDLE.
REQ-032 7 words only -> out_valid stays 0 indefinitely, level=7; the 8th word triggers the burst.
REQ-033 16 words, out_ready toggling 1/0 -> 2 bursts with beats held stable when stalled, no gap between bursts, burst_cnt=2.
REQ-034 out_ready=0, 33 words -> level=32, overflow=1, word 33 lost; drain gives words 1..32 in order.
REQ-035 level=32 with a same-cycle write and transfer -> write accepted, level stays 32, overflow stays 0.
REQ-036 rst asserted at beat 4 of a burst -> next cycle out_valid=0, level=0, burst_cnt=0, no out_last observed.
